// File: rtl/mul_sequencer.sv
// Multi-cycle shift-and-add multiplier for MULT/MULTU: one partial product per cycle,
// sign fixed up at the end, 64-bit result presented on HI/LO with a one-cycle DONE pulse.
module mul_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SIGNED,
    input  logic [DATA_WIDTH-1:0] SRC_A,
    input  logic [DATA_WIDTH-1:0] SRC_B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t                    state, state_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0]     mcand, mcand_nxt;
    logic [DATA_WIDTH:0]       acc, acc_nxt;
    logic [DATA_WIDTH-1:0]     low, low_nxt;
    logic                      neg, neg_nxt;
    logic                      busy_nxt, done_nxt;
    logic [DATA_WIDTH-1:0]     hi_nxt, lo_nxt;

    logic [DATA_WIDTH-1:0]     mag_a, mag_b;
    logic [DATA_WIDTH-1:0]     addend;
    logic [DATA_WIDTH:0]       sum;
    logic [2*DATA_WIDTH-1:0]   prod, prod_fix;

    // Operand magnitudes; 0x80..0 maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        mag_a = (SIGNED && SRC_A[DATA_WIDTH-1]) ? (~SRC_A + DATA_WIDTH'(1)) : SRC_A;
        mag_b = (SIGNED && SRC_B[DATA_WIDTH-1]) ? (~SRC_B + DATA_WIDTH'(1)) : SRC_B;
    end

    // acc[DATA_WIDTH] is always zero after the shift, so adding the full acc keeps the carry semantics.
    always_comb begin
        addend   = low[0] ? mcand : '0;
        sum      = acc + {1'b0, addend};
        prod     = {acc[DATA_WIDTH-1:0], low};
        prod_fix = neg ? (~prod + (2*DATA_WIDTH)'(1)) : prod;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mcand_nxt = mcand;
        acc_nxt   = acc;
        low_nxt   = low;
        neg_nxt   = neg;
        busy_nxt  = BUSY;
        done_nxt  = 1'b0;
        hi_nxt    = HI;
        lo_nxt    = LO;

        case (state)
            IDLE: begin
                if (START) begin
                    mcand_nxt = mag_a;
                    low_nxt   = mag_b;
                    acc_nxt   = '0;
                    neg_nxt   = SIGNED & (SRC_A[DATA_WIDTH-1] ^ SRC_B[DATA_WIDTH-1]);
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                {acc_nxt, low_nxt} = {sum, low} >> 1;
                cnt_nxt            = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                {hi_nxt, lo_nxt} = prod_fix;
                done_nxt         = 1'b1;
                busy_nxt         = 1'b0;
                cnt_nxt          = '0;
                state_nxt        = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            acc   <= '0;
            low   <= '0;
            neg   <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            mcand <= mcand_nxt;
            acc   <= acc_nxt;
            low   <= low_nxt;
            neg   <= neg_nxt;
            BUSY  <= busy_nxt;
            DONE  <= done_nxt;
            HI    <= hi_nxt;
            LO    <= lo_nxt;
        end
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle shift-and-add sequencer for 32x32 MULT/MULTU. It repeatedly drives one (DATA_WIDTH+1)-bit accumulate addition, one partial product per cycle, and returns a 64-bit product split into HI/LO. It sits beside the ALU in the execute stage. The processor's main control stalls the PC while BUSY is high and writes HI/LO when DONE pulses.

## Interface
- DATA_WIDTH, 32, operand width; products are 2*DATA_WIDTH bits.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- START  in  1  request a multiply; sampled only in IDLE.
- SIGNED  in  1  1 = MULT (two's complement), 0 = MULTU; captured with START.
- SRC_A  in  DATA_WIDTH  multiplicand; captured with START.
- SRC_B  in  DATA_WIDTH  multiplier; captured with START.
- BUSY  out  1  high while an operation is in flight.
- DONE  out  1  one-cycle pulse when HI/LO hold the new product.
- HI  out  DATA_WIDTH  upper half of product; held until the next completion.
- LO  out  DATA_WIDTH  lower half of product; held until the next completion.

## Operation
- States: IDLE, RUN, FIX. There is no explicit DONE state; DONE is a registered flag.
- IDLE:
  - On START=1, latch MCAND = |SRC_A| (magnitude if SIGNED, else raw).
  - Latch the multiplier magnitude |SRC_B| into the LO working register.
  - Clear the ACC (HI working, DATA_WIDTH+1 bits).
  - Latch NEG = SIGNED & (SRC_A[MSB] ^ SRC_B[MSB]).
  - Set CNT=0 and go to RUN.
- Magnitude rule: |x| = ~x+1 when x[MSB]=1 and SIGNED=1. For 0x80000000 this yields unsigned 0x80000000, which is correct as an unsigned magnitude.
- RUN, one iteration per cycle:
  - SUM = ACC[DATA_WIDTH-1:0] + (LOW[0] ? MCAND : 0), computed in DATA_WIDTH+1 bits with the carry kept.
  - {ACC, LOW} <= {SUM, LOW} >> 1, a logical right shift of the 2*DATA_WIDTH+1-bit concatenation.
  - CNT <= CNT+1. After the iteration with CNT = DATA_WIDTH-1, go to FIX.
- FIX:
  - If NEG=1, P = two's complement of the 64-bit {ACC, LOW}; otherwise P = {ACC, LOW}.
  - Write {HI, LO} <= P, pulse DONE, and return to IDLE.
- Operand changes on SRC_A, SRC_B and SIGNED after the START edge have no effect.
- START while BUSY=1 is ignored: no queueing and no error.
- HI/LO change only in FIX. The outputs of the previous product stay stable for the whole of the next operation.

## Timing
- Reset (RST=1 at an edge, in any state, including mid-operation):
  - State goes to IDLE, CNT=0.
  - BUSY=0, DONE=0, HI=0, LO=0.
  - The in-flight operation is discarded with no DONE pulse.
- Latency: call the START-sampling edge E0.
  - RUN occupies edges E1..E32.
  - FIX is executed at edge E33, which registers HI/LO and DONE=1.
  - DONE is visible for exactly one cycle after E33. The total is 33 cycles from START accepted to result valid.
- BUSY is registered. It rises at E0 and falls at E33, the same edge at which DONE rises, so BUSY and DONE are never high together.
- Back-to-back: START may be high in the DONE cycle. It is accepted at the next edge, because the state is IDLE. Sustained throughput is one product per 34 cycles.
- DONE is deasserted at the next edge regardless of START.
- Control signals are a function of registered state only; there are no combinational paths from inputs to BUSY or DONE.

## Test plan
- Reset: after reset, HI=0, LO=0, BUSY=0, DONE=0. A START pulse at E0 gives BUSY=1 from E0 through E32 and DONE=1 exactly one cycle after E33.
- MULTU small and large:
  - 3 x 5 gives HI=0x00000000, LO=0x0000000F.
  - 0xFFFFFFFF x 0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001.
- MULT signs:
  - -1 x -1 gives HI=0, LO=1.
  - -2 x 3 gives HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - 0x80000000 x 0x80000000 gives HI=0x40000000, LO=0.
  - 0x80000000 x 1 gives HI=0xFFFFFFFF, LO=0x80000000.
- Input stability:
  - Change SRC_A/SRC_B/SIGNED and pulse START mid-RUN: the result matches the originally latched operands, with one DONE only.
  - HI/LO keep the prior product until E33.
- Reset mid-op: assert RST at E10 of a 7 x 9 MULTU. The response is the idle state with HI=LO=0, no DONE, and BUSY=0 after the edge. A fresh START then yields LO=63.
- Back-to-back: assert START in the DONE cycle with 0x10000 x 0x10000 MULTU. It is accepted, and the second DONE arrives 34 cycles after the first with HI=0x00000001, LO=0.
